// File: rtl/neuron_update_pkg.sv
// Shared parameters, spin codes, FSM encoding and the signed MAC term helper
// for the neuron update block.
package neuron_update_pkg;

  localparam int N    = 20;  // history taps
  localparam int WW   = 8;   // signed weight width
  localparam int ACCW = 14;  // signed accumulator width, WW+1+ceil(log2 N)
  localparam int AW   = 5;   // weight address width

  localparam logic [AW-1:0] N_ADDR    = AW'(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  localparam logic [1:0] SPIN_POS = 2'b01;
  localparam logic [1:0] SPIN_NEG = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACC    = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;

  // Full signed product of a weight and a 2-bit signed tap code, sign-extended
  // to the accumulator width. WW+2 bits hold the extreme -128 * -2 = +256.
  function automatic logic signed [ACCW-1:0] mac_term(
    input logic signed [WW-1:0] w,
    input logic signed [1:0]    tap
  );
    logic signed [WW+1:0] w_ext;
    logic signed [WW+1:0] t_ext;
    logic signed [WW+1:0] prod;
    w_ext = {{2{w[WW-1]}}, w};
    t_ext = {{WW{tap[1]}}, tap};
    prod  = w_ext * t_ext;
    return {{(ACCW-WW-2){prod[WW+1]}}, prod};
  endfunction

endpackage

// File: rtl/neuron_update_weight_regfile.sv
// N x WW signed weight file: one synchronous write port that drops
// out-of-range addresses, one combinational read port, async clear.
module weight_regfile
  import neuron_update_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [WW-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic signed [WW-1:0] rdata
);

  logic signed [WW-1:0] w_q [N];
  logic signed [WW-1:0] w_d [N];

  // Next weight contents: apply an in-range write, otherwise hold.
  always_comb begin
    w_d = w_q;
    if (we && (waddr < N_ADDR)) begin
      w_d[waddr] = wdata;
    end else begin
      w_d = w_q;
    end
  end

  // Weight storage with asynchronous clear to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        w_q[i] <= {WW{1'b0}};
      end
    end else begin
      w_q <= w_d;
    end
  end

  // Combinational read of the current (pre-write) contents, so a same-edge
  // write never disturbs the tap being accumulated.
  always_comb begin
    if (raddr < N_ADDR) begin
      rdata = w_q[raddr];
    end else begin
      rdata = {WW{1'b0}};
    end
  end

endmodule

// File: rtl/neuron_update.sv
// Neuron update: snapshots the spin history, accumulates one signed
// weight*tap product per cycle and thresholds the sum into the next spin.
module neuron_update
  import neuron_update_pkg::*;
(
  input  logic                   update_clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2*N-1:0]         xalt_packed,
  input  logic signed [ACCW-1:0] threshold,
  input  logic                   w_we,
  input  logic [AW-1:0]          w_addr,
  input  logic signed [WW-1:0]   w_data,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             xin,
  output logic signed [ACCW-1:0] sum
);

  logic [1:0]             state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [2*N-1:0]         xalt_q, xalt_d;
  logic signed [ACCW-1:0] thr_q, thr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [1:0]             xin_q, xin_d;
  logic signed [ACCW-1:0] sum_q, sum_d;

  logic signed [WW-1:0]   w_rd_s;
  logic signed [1:0]      tap_s;

  weight_regfile u_weights (
    .clk   (update_clk),
    .rst_n (rst_n),
    .we    (w_we),
    .waddr (w_addr),
    .wdata (w_data),
    .raddr (idx_q),
    .rdata (w_rd_s)
  );

  // Select the snapshot tap addressed by the current index.
  always_comb begin
    tap_s = xalt_q[{idx_q, 1'b0} +: 2];
  end

  // FSM and datapath next-state: snapshot in IDLE, MAC in ACC, threshold in DECIDE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    xalt_d  = xalt_q;
    thr_d   = thr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    xin_d   = xin_q;
    sum_d   = sum_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACC;
          xalt_d  = xalt_packed;
          thr_d   = threshold;
          acc_d   = {ACCW{1'b0}};
          idx_d   = {AW{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        acc_d = acc_q + mac_term(w_rd_s, tap_s);
        if (idx_q == LAST_ADDR) begin
          state_d = ST_DECIDE;
          idx_d   = {AW{1'b0}};
        end else begin
          idx_d   = idx_q + 5'd1;
        end
      end
      ST_DECIDE: begin
        sum_d   = acc_q;
        xin_d   = (acc_q >= thr_q) ? SPIN_POS : SPIN_NEG;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        idx_d   = {AW{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous reset to idle values.
  always_ff @(posedge update_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= {AW{1'b0}};
      acc_q   <= {ACCW{1'b0}};
      xalt_q  <= {(2*N){1'b0}};
      thr_q   <= {ACCW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      xin_q   <= SPIN_POS;
      sum_q   <= {ACCW{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      xalt_q  <= xalt_d;
      thr_q   <= thr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      xin_q   <= xin_d;
      sum_q   <= sum_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign xin  = xin_q;
  assign sum  = sum_q;

endmodule

// File: tb/tb_neuron_update.sv
// Scoreboard bench for neuron_update: stimulus pushes expected results from a
// plain-arithmetic reference model, a monitor pops and compares on done.
module tb_neuron_update;
  localparam int N    = 20;
  localparam int WW   = 8;
  localparam int ACCW = 14;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [2*N-1:0]         xalt_packed = '0;
  logic signed [ACCW-1:0] threshold = '0;
  logic                   w_we = 1'b0;
  logic [4:0]             w_addr = '0;
  logic signed [WW-1:0]   w_data = '0;
  logic                   busy, done;
  logic [1:0]             xin;
  logic signed [ACCW-1:0] sum;

  neuron_update dut (
    .update_clk(clk), .rst_n(rst_n), .start(start), .xalt_packed(xalt_packed),
    .threshold(threshold), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .xin(xin), .sum(sum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int s; int x; int due; } exp_t;
  exp_t sb[$];
  int wm [N];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int tap_val(input logic [1:0] c);
    case (c)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b10:   return -2;
      default: return -1;
    endcase
  endfunction

  function automatic int model_sum(input logic [2*N-1:0] xa);
    int s = 0;
    for (int j = 0; j < N; j++) s += wm[j] * tap_val(xa[2*j +: 2]);
    return s;
  endfunction

  function automatic logic [2*N-1:0] fill_taps(input logic [1:0] c);
    logic [2*N-1:0] v;
    for (int j = 0; j < N; j++) v[2*j +: 2] = c;
    return v;
  endfunction

  function automatic logic [2*N-1:0] rand_taps();
    logic [2*N-1:0] v;
    for (int j = 0; j < N; j++) v[2*j +: 2] = 2'($urandom_range(0, 3));
    return v;
  endfunction

  // Monitor: every done must match the oldest expected result and its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sum", int'(sum), e.s);
          check("xin", int'(xin), e.x);
          check("done_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic write_w(input int addr, input int data);
    @(negedge clk);
    w_we = 1'b1; w_addr = 5'(addr); w_data = 8'(data);
    @(posedge clk); #1;
    w_we = 1'b0;
    if (addr < N) wm[addr] = data;
  endtask

  // Drive start now (caller is between edges); returns the accepting edge count.
  task automatic start_eval(input logic [2*N-1:0] xa, input int thr, output int k);
    int s;
    xalt_packed = xa; threshold = ACCW'(thr); start = 1'b1;
    s = model_sum(xa);
    @(posedge clk); #1;
    k = cyc; start = 1'b0;
    sb.push_back('{s, (s >= thr) ? 1 : 3, k + N + 1});
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (i == 200) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic eval(input logic [2*N-1:0] xa, input int thr);
    int k;
    wait_drain();
    start_eval(xa, thr, k);
    wait_drain();
  endtask

  initial begin
    int k, s, i;
    logic [2*N-1:0] xa;
    for (int j = 0; j < N; j++) wm[j] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_xin", int'(xin), 1);
    check("rst_sum", int'(sum), 0);
    @(negedge clk); rst_n = 1'b1;

    // All ones, taps +1: sum 20, latency checked by the monitor.
    for (int j = 0; j < N; j++) write_w(j, 1);
    eval(fill_taps(2'b01), 0);
    // Ramp weights j-10.
    for (int j = 0; j < N; j++) write_w(j, j - 10);
    eval(fill_taps(2'b11), 0);
    eval(fill_taps(2'b01), 0);
    // Extreme products.
    for (int j = 0; j < N; j++) write_w(j, -128);
    eval(fill_taps(2'b10), 0);
    eval(fill_taps(2'b10), 5121);
    eval(fill_taps(2'b10), 5120);
    // Equality boundary with random weights.
    for (int j = 0; j < N; j++) write_w(j, $urandom_range(0, 255) - 128);
    xa = rand_taps(); s = model_sum(xa);
    eval(xa, s);
    eval(xa, s + 1);
    eval(xa, s - 1);

    // start mid-ACC and input changes after the snapshot are ignored.
    wait_drain();
    xa = rand_taps();
    start_eval(xa, 7, k);
    repeat (5) @(negedge clk);
    start = 1'b1; xalt_packed = ~xa; threshold = 14'sd100;
    @(posedge clk); #1;
    start = 1'b0;

    // Back-to-back: start during the done cycle.
    wait_drain();
    start_eval(rand_taps(), -3, k);
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("b2b_done_seen", int'(i < 40), 1);
    start_eval(rand_taps(), 3, k);
    wait_drain();

    // Out-of-range address writes change nothing.
    write_w(25, 77);
    write_w(20, -5);
    write_w(31, 99);
    eval(fill_taps(2'b01), 0);

    // Same-edge write to w[3]: old weight now, new weight next time.
    write_w(3, 10);
    wait_drain();
    start_eval(fill_taps(2'b01), 0, k);
    repeat (3) @(posedge clk);
    @(negedge clk);
    w_we = 1'b1; w_addr = 5'd3; w_data = -8'sd60;
    @(posedge clk); #1;
    w_we = 1'b0; wm[3] = -60;
    wait_drain();
    eval(fill_taps(2'b01), 0);

    // Reset mid-ACC after a result with xin=-1.
    for (int j = 0; j < N; j++) write_w(j, 5);
    eval(fill_taps(2'b11), 0);
    start_eval(fill_taps(2'b01), 0, k);
    repeat (5) @(negedge clk);
    rst_n = 1'b0; #1;
    sb.delete();
    for (int j = 0; j < N; j++) wm[j] = 0;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_xin", int'(xin), 1);
    check("mid_rst_sum", int'(sum), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    eval(fill_taps(2'b10), 0);
    eval(fill_taps(2'b01), 0);

    // Randomized evaluations with random writes between them.
    for (int n = 0; n < 25; n++) begin
      for (int m = 0; m < 4; m++) write_w($urandom_range(0, 31), $urandom_range(0, 255) - 128);
      eval(rand_taps(), $urandom_range(0, 10400) - 5200);
    end

    wait_drain();
    repeat (30) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d, mismatched %0d", n_cmp, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/neuron_update.md
# neuron_update

Consumer side of the neuron history register: reads the 20-entry packed spin history, computes a signed weighted sum serially against a programmable weight file, and thresholds it into the next spin value. The resulting `xin` and a one-cycle `done` strobe feed the history shift register's input on the following update. One multiply-accumulate per cycle; a new evaluation starts only from idle.

## Interface
- `N`, 20: number of history taps (spins in `xalt_packed`).
- `WW`, 8: signed weight width.
- `ACCW`, 14: signed accumulator width, equal to WW+1+ceil(log2 N); must not overflow.
- `update_clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one evaluation; honoured only in IDLE.
- `xalt_packed`  in  2*N  spin history; tap j is bits [2j+1:2j], 2-bit signed.
- `threshold`  in  ACCW  signed firing threshold, sampled with `start`.
- `w_we`  in  1  weight write enable.
- `w_addr`  in  5  weight index.
- `w_data`  in  WW  signed weight.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  one-cycle pulse; `xin` and `sum` are valid from this cycle on.
- `xin`  out  2  next spin: 2'b01 (+1) or 2'b11 (-1).
- `sum`  out  ACCW  signed weighted sum from the last evaluation.

## Operation
- FSM states:
  - IDLE: `start` moves to ACC. Same edge: snapshot `xalt_packed` and `threshold`, clear `acc`, set idx=0, set `busy`.
  - ACC: each edge does acc += w[idx] * tap[idx], with full signed product sign-extended to ACCW, then idx++. After idx=N-1 is accumulated, go to DECIDE.
  - DECIDE: one edge. Load `sum`<=acc. Set `xin`<=01 if acc >= threshold (signed), else 11. Assert `done`, clear `busy`, return to IDLE.
- Tap value is the raw 2-bit signed code: 01=+1, 11=-1, 00=0, 10=-2. All four codes are legal.
- Products are signed WW+2 bits. The worst case is -128 * -2 = +256, so 20 taps peak at ±5120, which fits in 14 bits. No saturation.
- Weight file is N x WW, cleared to 0 on reset. A write with `w_addr` >= N is ignored.
- Weight writes are accepted in every state. A write and an ACC read of the same index on the same edge: the read uses the old weight. A write to an already-consumed index affects only the next evaluation.
- `start` while busy is ignored, with no queueing. Changes on `xalt_packed` or `threshold` after the snapshot have no effect.
- `xin` and `sum` hold their values between evaluations.

## Timing
- Reset values: `busy`=0, `done`=0, `xin`=2'b01, `sum`=0. State is IDLE and all weights are 0.
- `start` sampled high at edge k:
  - `busy`=1 after edge k.
  - Taps 0..N-1 are accumulated on edges k+1..k+N.
  - DECIDE on edge k+N+1: `done`=1, `busy`=0, new `xin`/`sum` visible.
  - `done` drops after edge k+N+2.
- Latency is N+1 = 21 cycles from the accepting edge to `done`.
- Back-to-back: `start` high during the `done` cycle is accepted, because the FSM is already in IDLE. Throughput is one evaluation per N+2 cycles.
- `rst_n` low at any time, including mid-ACC, immediately forces the reset values and clears the weights. The in-flight evaluation is lost and no `done` is produced.

## Structure
- Shared package holds:
  - N, WW, ACCW;
  - spin codes SPIN_POS=2'b01, SPIN_NEG=2'b11;
  - FSM state encoding IDLE/ACC/DECIDE.
- Sub-module `weight_regfile`: N x WW registers. One synchronous write port, one combinational read port indexed by idx, async active-low clear.
- Top level holds the FSM, snapshot registers, multiplier and accumulator.

## Test plan
- Reset, write all weights = 1, `xalt_packed` all 01, `threshold`=0, pulse `start` -> `done` exactly 21 cycles later, `sum`=20, `xin`=01.
- Weights w[j]=j-10, taps all 11, `threshold`=0 -> `sum`=+10, `xin`=01.
  - Same weights, taps all 01 -> `sum`=-10, `xin`=11.
- All weights -128, taps all 10 -> `sum`=5120, no overflow. Then `threshold`=5121 -> `xin`=11.
- Equality boundary: `sum` equal to `threshold` -> `xin`=01.
- `start` pulsed mid-ACC and `xalt_packed` changed after acceptance -> ignored; result matches the snapshot.
  - `start` during the `done` cycle -> second `done` 22 cycles after the first.
- Assert `rst_n` low 5 cycles into ACC -> `busy`/`done`=0, `xin`=01, weights=0. After release, an evaluation gives `sum`=0 and `xin`=01 with `threshold`=0.
- Write to w_addr=25 -> no weight changes.
  - Write w[3] on the same edge it is read -> old value is used this time, new value on the next evaluation.
